univ_shift_counter: RTL and testbench

Parametrised universal shift register / counter. It is the sequential successor to the enable-gated 2:1 behavioural mux used to steer data in the shift-register datapath. A WIDTH-bit register whose next state is selected by a 2-bit mode:
- shift, with serial in/out
- rotate
- parallel load
- up/down count, with ripple-carry flag

Used as the configurable storage/count element in the shifting-register and binary-counter designs.

---
 rtl/univ_shift_counter.sv | 99 +++++++++
 tb/tb_univ_shift_counter.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/univ_shift_counter.sv
// rtl/univ_shift_counter.sv - universal shift register / up-down counter with serial out and ripple-carry flag
module univ_shift_counter #(
    parameter int WIDTH = 4
) (
    input  logic             CLK,
    input  logic             RST_L,
    input  logic             ENB,
    input  logic             DIR,
    input  logic [1:0]       MODO,
    input  logic             S_IN,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic             S_OUT,
    output logic             RCO
);

    typedef enum logic [1:0] {
        MODE_SHIFT  = 2'b00,
        MODE_ROTATE = 2'b01,
        MODE_LOAD   = 2'b10,
        MODE_COUNT  = 2'b11
    } mode_e;

    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ALL_ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] q_q, q_d;
    logic             s_out_q, s_out_d;
    logic             rco_q, rco_d;
    mode_e            mode;

    assign mode = mode_e'(MODO);

    // Next-state select: hold by default; RCO is a one-edge pulse so it defaults low.
    always_comb begin
        q_d     = q_q;
        s_out_d = s_out_q;
        rco_d   = 1'b0;
        if (ENB) begin
            unique case (mode)
                MODE_SHIFT: begin
                    if (DIR) begin
                        q_d     = {S_IN, q_q[WIDTH-1:1]};
                        s_out_d = q_q[0];
                    end else begin
                        q_d     = {q_q[WIDTH-2:0], S_IN};
                        s_out_d = q_q[WIDTH-1];
                    end
                end
                MODE_ROTATE: begin
                    if (DIR) begin
                        q_d     = {q_q[0], q_q[WIDTH-1:1]};
                        s_out_d = q_q[0];
                    end else begin
                        q_d     = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
                        s_out_d = q_q[WIDTH-1];
                    end
                end
                MODE_LOAD: begin
                    q_d     = D;
                    s_out_d = 1'b0;
                end
                MODE_COUNT: begin
                    s_out_d = 1'b0;
                    if (DIR) begin
                        q_d   = q_q - ONE;
                        rco_d = (q_q == ALL_ZERO);
                    end else begin
                        q_d   = q_q + ONE;
                        rco_d = (q_q == ALL_ONES);
                    end
                end
                default: begin
                    q_d     = q_q;
                    s_out_d = s_out_q;
                end
            endcase
        end
    end

    // State register; reset clears everything immediately, independent of the clock.
    always_ff @(posedge CLK or negedge RST_L) begin
        if (!RST_L) begin
            q_q     <= ALL_ZERO;
            s_out_q <= 1'b0;
            rco_q   <= 1'b0;
        end else begin
            q_q     <= q_d;
            s_out_q <= s_out_d;
            rco_q   <= rco_d;
        end
    end

    assign Q     = q_q;
    assign S_OUT = s_out_q;
    assign RCO   = rco_q;

endmodule

// File: tb/tb_univ_shift_counter.sv
// tb/tb_univ_shift_counter.sv - directed table-driven bench for univ_shift_counter
module tb_univ_shift_counter;

    localparam int WIDTH = 4;

    logic             CLK;
    logic             RST_L;
    logic             ENB;
    logic             DIR;
    logic [1:0]       MODO;
    logic             S_IN;
    logic [WIDTH-1:0] D;
    logic [WIDTH-1:0] Q;
    logic             S_OUT;
    logic             RCO;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic             enb;
        logic             dir;
        logic [1:0]       modo;
        logic             s_in;
        logic [WIDTH-1:0] d;
        logic [WIDTH-1:0] exp_q;
        logic             exp_sout;
        logic             exp_rco;
    } vec_t;

    vec_t vecs[$];

    univ_shift_counter #(.WIDTH(WIDTH)) dut (
        .CLK   (CLK),
        .RST_L (RST_L),
        .ENB   (ENB),
        .DIR   (DIR),
        .MODO  (MODO),
        .S_IN  (S_IN),
        .D     (D),
        .Q     (Q),
        .S_OUT (S_OUT),
        .RCO   (RCO)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic add(input logic enb, input logic dir, input logic [1:0] modo,
                       input logic s_in, input logic [WIDTH-1:0] d,
                       input logic [WIDTH-1:0] q, input logic so, input logic rco);
        vec_t v;
        v.enb = enb; v.dir = dir; v.modo = modo; v.s_in = s_in; v.d = d;
        v.exp_q = q; v.exp_sout = so; v.exp_rco = rco;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [WIDTH-1:0] q,
                         input logic so, input logic rco);
        checks++;
        if (Q !== q) begin
            errors++;
            $display("FAIL %s Q: got %b expected %b", name, Q, q);
        end
        checks++;
        if (S_OUT !== so) begin
            errors++;
            $display("FAIL %s S_OUT: got %b expected %b", name, S_OUT, so);
        end
        checks++;
        if (RCO !== rco) begin
            errors++;
            $display("FAIL %s RCO: got %b expected %b", name, RCO, rco);
        end
    endtask

    task automatic step(input logic enb, input logic dir, input logic [1:0] modo,
                        input logic s_in, input logic [WIDTH-1:0] d);
        ENB = enb; DIR = dir; MODO = modo; S_IN = s_in; D = d;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        //   enb dir modo   sin d        q        so   rco
        // load then shift left with S_IN=1
        add(1, 0, 2'b10, 0, 4'b1001, 4'b1001, 0, 0);
        add(1, 0, 2'b00, 1, 4'b0000, 4'b0011, 1, 0);
        add(1, 0, 2'b00, 1, 4'b0000, 4'b0111, 0, 0);
        add(1, 0, 2'b00, 1, 4'b0000, 4'b1111, 0, 0);
        add(1, 0, 2'b00, 1, 4'b0000, 4'b1111, 1, 0);
        // rotate right from 0001 (S_IN ignored)
        add(1, 0, 2'b10, 0, 4'b0001, 4'b0001, 0, 0);
        add(1, 1, 2'b01, 0, 4'b0000, 4'b1000, 1, 0);
        add(1, 1, 2'b01, 1, 4'b0000, 4'b0100, 0, 0);
        add(1, 1, 2'b01, 0, 4'b0000, 4'b0010, 0, 0);
        add(1, 1, 2'b01, 1, 4'b0000, 4'b0001, 0, 0);
        // count up through wrap
        add(1, 0, 2'b10, 0, 4'b1110, 4'b1110, 0, 0);
        add(1, 0, 2'b11, 0, 4'b0000, 4'b1111, 0, 0);
        add(1, 0, 2'b11, 0, 4'b0000, 4'b0000, 0, 1);
        add(1, 0, 2'b11, 0, 4'b0000, 4'b0001, 0, 0);
        // count down through wrap, then reverse
        add(1, 1, 2'b11, 0, 4'b0000, 4'b0000, 0, 0);
        add(1, 1, 2'b11, 0, 4'b0000, 4'b1111, 0, 1);
        add(1, 0, 2'b11, 0, 4'b0000, 4'b0000, 0, 1);
        // enable hold during count at 0101 with other inputs toggling
        add(1, 0, 2'b10, 0, 4'b0100, 4'b0100, 0, 0);
        add(1, 0, 2'b11, 0, 4'b0000, 4'b0101, 0, 0);
        add(0, 1, 2'b10, 1, 4'b1010, 4'b0101, 0, 0);
        add(0, 0, 2'b00, 0, 4'b0011, 4'b0101, 0, 0);
        add(0, 1, 2'b01, 1, 4'b1111, 4'b0101, 0, 0);
        add(1, 0, 2'b11, 0, 4'b0000, 4'b0110, 0, 0);
        // wrap edge swallowed by ENB=0, then resumed
        add(1, 0, 2'b10, 0, 4'b1111, 4'b1111, 0, 0);
        add(0, 0, 2'b11, 0, 4'b0000, 4'b1111, 0, 0);
        add(1, 0, 2'b11, 0, 4'b0000, 4'b0000, 0, 1);
        // shift right and rotate left
        add(1, 0, 2'b10, 0, 4'b0110, 4'b0110, 0, 0);
        add(1, 1, 2'b00, 1, 4'b0000, 4'b1011, 0, 0);
        add(1, 1, 2'b00, 0, 4'b0000, 4'b0101, 1, 0);
        add(1, 0, 2'b01, 0, 4'b0000, 4'b1010, 0, 0);
        add(1, 0, 2'b01, 1, 4'b0000, 4'b0101, 1, 0);
        // S_OUT holds under ENB=0; load clears it; count down from zero wraps
        add(0, 0, 2'b11, 0, 4'b0000, 4'b0101, 1, 0);
        add(1, 1, 2'b10, 1, 4'b0000, 4'b0000, 0, 0);
        add(1, 1, 2'b11, 0, 4'b0000, 4'b1111, 0, 1);
        // RCO drops on the edge after the wrap even without leaving count mode
        add(1, 1, 2'b11, 0, 4'b0000, 4'b1110, 0, 0);

        RST_L = 1'b0; ENB = 1'b0; DIR = 1'b0; MODO = 2'b00; S_IN = 1'b0; D = '0;
        #1;
        check("reset_initial", 4'b0000, 0, 0);
        @(posedge CLK); #1;
        @(negedge CLK);
        RST_L = 1'b1;
        @(posedge CLK); #1;
        check("reset_release_hold", 4'b0000, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].enb, vecs[i].dir, vecs[i].modo, vecs[i].s_in, vecs[i].d);
            check($sformatf("vec%0d", i), vecs[i].exp_q, vecs[i].exp_sout, vecs[i].exp_rco);
        end

        // Asynchronous reset between edges with Q=1011, S_OUT=1
        step(1, 0, 2'b10, 0, 4'b1101);
        step(1, 0, 2'b01, 0, 4'b0000);
        check("pre_reset", 4'b1011, 1, 0);
        #3;
        RST_L = 1'b0;
        #1;
        check("async_reset_mid_cycle", 4'b0000, 0, 0);
        @(negedge CLK);
        RST_L = 1'b1;
        step(0, 0, 2'b10, 1, 4'b1111);
        check("post_reset_hold1", 4'b0000, 0, 0);
        step(0, 1, 2'b11, 1, 4'b1111);
        check("post_reset_hold2", 4'b0000, 0, 0);
        step(1, 1, 2'b11, 0, 4'b0000);
        check("post_reset_first_op", 4'b1111, 0, 1);

        // Reset asserted with a wrap in flight: RCO pulse is aborted
        step(1, 0, 2'b11, 0, 4'b0000);
        check("wrap_before_reset", 4'b0000, 0, 1);
        step(1, 0, 2'b10, 0, 4'b1111);
        ENB = 1'b1; DIR = 1'b0; MODO = 2'b11;
        @(negedge CLK);
        RST_L = 1'b0;
        @(posedge CLK); #1;
        check("reset_blocks_wrap", 4'b0000, 0, 0);
        @(negedge CLK);
        RST_L = 1'b1;
        step(1, 0, 2'b11, 0, 4'b0000);
        check("count_after_reset", 4'b0001, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
